button_debouncer: RTL and testbench

Conditions one raw, active-low push-button input for the display counter top level. It synchronises, debounces, and edge-detects the input. It produces a clean level, single-cycle press/release strobes and a run/pause toggle that drives the counter enable. It sits directly upstream of the counter's en input and replaces the bare inversion of the button.

---
 rtl/btn_pkg.sv | 16 +
 rtl/sync_2ff.sv | 37 +++
 rtl/button_debouncer.sv | 179 +++++++++++++++++
 tb/tb_button_debouncer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning block:
// debounce FSM state encoding and synchroniser depth.
package btn_pkg;

  // Two-bit debounce FSM state encoding.
  typedef logic [1:0] state_t;

  localparam state_t IDLE         = 2'd0;
  localparam state_t PRESS_WAIT   = 2'd1;
  localparam state_t PRESSED      = 2'd2;
  localparam state_t RELEASE_WAIT = 2'd3;

  // Number of flops between the raw pin and the debounce FSM.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic flop-chain synchroniser (SYNC_STAGES deep, 2 by default).
// Resets to 1 so an active-low input reads as "inactive" out of reset,
// which makes it reusable for both the button and a reset push-button.
module sync_2ff
  import btn_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic [SYNC_STAGES-1:0] stage_d;

  // Stage 0 captures the asynchronous input; each later stage copies the previous one.
  assign stage_d[0] = d_in;

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
      assign stage_d[gi] = stage_q[gi-1];
    end
  endgenerate

  // Shift chain with synchronous active-low reset to all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '1;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises the raw active-low button, debounces
// it with a 4-state FSM, and produces a clean level, press/release strobes and
// a run/pause toggle feeding the counter enable.
// `release` is a reserved word, so the release strobe port is named release_o.
// Optional feature macro: BTN_LONG_PRESS_EN adds the long_press strobe and the
// hold counter behind it; without it neither exists.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int CNT_W             = 20,
  parameter int LONG_PRESS_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic release_o,
  output logic run
`ifdef BTN_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  // Reject parameter sets whose counters would not fit in CNT_W bits.
  generate
    if ((DEBOUNCE_CYCLES < 2) ||
        (64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) ||
        (64'(LONG_PRESS_CYCLES) >= (64'd1 << CNT_W))) begin : g_param_check
      $error("button_debouncer: DEBOUNCE_CYCLES/LONG_PRESS_CYCLES do not fit CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic   btn_sync_n;
  logic   s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             run_q, run_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_in  (btn_n),
    .q_out (btn_sync_n)
  );

  // Synchronised button, 1 = pressed.
  assign s = ~btn_sync_n;

  // Debounce FSM: a new level is accepted only after DEBOUNCE_CYCLES stable samples.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          cnt_d   = CNT_W'(1);
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = '0;
          state_d = PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          cnt_d   = CNT_W'(1);
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_q == DB_LAST) begin
          cnt_d     = '0;
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Level follows the accepted state, so it changes in the same cycle as the strobes.
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    run_d   = run_q ^ press_d;
  end

  // FSM, counter and registered outputs; reset wins over any in-flight debounce.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      run_q     <= run_d;
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = release_q;
  assign run       = run_q;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             fired_q, fired_d;
  logic             long_q, long_d;

  // Hold timer: counts held cycles in PRESSED, fires once per accepted press.
  always_comb begin
    hold_d  = hold_q;
    fired_d = fired_q;
    long_d  = 1'b0;
    if (press_d) begin
      hold_d  = '0;
      fired_d = 1'b0;
    end else if (state_q == PRESSED) begin
      if (!s) begin
        // Leaving for RELEASE_WAIT; a bounce back resumes from zero.
        hold_d = '0;
      end else if (hold_q != LP_LAST) begin
        hold_d = hold_q + CNT_W'(1);
      end else if (!fired_q) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end
    end
  end

  // Hold timer state and registered long-press strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  assign long_press = long_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed testbench for button_debouncer with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=10. Long-press scenarios build only with BTN_LONG_PRESS_EN.
module tb_button_debouncer;

  localparam int DB = 4;
  localparam int LP = 10;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_n;
  logic level;
  logic press;
  logic release_o;
  logic run;
`ifdef BTN_LONG_PRESS_EN
  logic long_press;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES   (DB),
    .CNT_W             (CW),
    .LONG_PRESS_CYCLES (LP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .level     (level),
    .press     (press),
    .release_o (release_o),
    .run       (run)
`ifdef BTN_LONG_PRESS_EN
    ,
    .long_press(long_press)
`endif
  );

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] outs;
    rst   = 1'b0;
    btn_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      btn_n = i[0];
      step();
      outs = {level, press, release_o, run};
      n_checks++;
      if (outs !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 0000", i, outs);
      end
      n_checks++;
      if (dut.state_q !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_state cycle %0d: got %0d expected 0 (IDLE)", i, dut.state_q);
      end
`ifdef BTN_LONG_PRESS_EN
      n_checks++;
      if (long_press !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_long_press cycle %0d: got %b expected 0", i, long_press);
      end
`endif
    end
    rst   = 1'b1;
    btn_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      outs = {level, press, release_o, run};
      n_checks++;
      if (outs !== 4'b0000) begin
        n_fail++;
        $display("FAIL post_reset_outputs cycle %0d: got %b expected 0000", i, outs);
      end
    end
    $display("test_reset done");
  endtask

  // Low 3, high 1, low 2, then high: too short every time to be accepted.
  task automatic test_bounce();
    logic [11:0] pattern;
    int presses;
    int level_seen;
    presses    = 0;
    level_seen = 0;
    pattern    = 12'b111111001000;  // bit i is btn_n for step i (LSB first)
    for (int i = 0; i < 18; i++) begin
      btn_n = (i < 12) ? pattern[i] : 1'b1;
      step();
      if (press === 1'b1) presses++;
      if (level !== 1'b0) level_seen++;
    end
    n_checks++;
    if (presses != 0) begin
      n_fail++;
      $display("FAIL bounce_press_count: got %0d expected 0", presses);
    end
    n_checks++;
    if (level_seen != 0) begin
      n_fail++;
      $display("FAIL bounce_level: level high in %0d cycles expected 0", level_seen);
    end
    n_checks++;
    if (run !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_run: got %b expected 0", run);
    end
    $display("test_bounce done: presses=%0d", presses);
  endtask

  task automatic test_clean_press();
    int presses;
    int first_idx;
    presses   = 0;
    first_idx = -1;
    btn_n     = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (press === 1'b1) begin
        presses++;
        if (first_idx < 0) first_idx = i;
      end
      if (i == 5) begin
        n_checks++;
        if (level !== 1'b0) begin
          n_fail++;
          $display("FAIL press_level_early: got %b expected 0", level);
        end
      end
      if (i == 6) begin
        n_checks++;
        if ({level, run} !== 2'b11) begin
          n_fail++;
          $display("FAIL press_level_run: got level=%b run=%b expected 1 1", level, run);
        end
      end
    end
    n_checks++;
    if (first_idx != 6) begin
      n_fail++;
      $display("FAIL press_latency: got %0d expected 6", first_idx);
    end
    n_checks++;
    if (presses != 1) begin
      n_fail++;
      $display("FAIL press_no_repeat: got %0d presses expected 1", presses);
    end
    $display("test_clean_press done: latency=%0d presses=%0d", first_idx, presses);
  endtask

  // From PRESSED: high 2, low 1, then high held.
  task automatic test_release_bounce();
    int rels;
    int first_idx;
    rels      = 0;
    first_idx = -1;
    btn_n = 1'b1;
    step();
    if (release_o === 1'b1) rels++;
    step();
    if (release_o === 1'b1) rels++;
    btn_n = 1'b0;
    step();
    if (release_o === 1'b1) rels++;
    n_checks++;
    if (level !== 1'b1) begin
      n_fail++;
      $display("FAIL release_bounce_level: got %b expected 1", level);
    end
    btn_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (release_o === 1'b1) begin
        rels++;
        if (first_idx < 0) first_idx = i;
        n_checks++;
        if (press !== 1'b0) begin
          n_fail++;
          $display("FAIL release_press_overlap: press=%b expected 0", press);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (level !== 1'b1) begin
          n_fail++;
          $display("FAIL release_level_early: got %b expected 1", level);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (level !== 1'b0) begin
          n_fail++;
          $display("FAIL release_level: got %b expected 0", level);
        end
      end
    end
    n_checks++;
    if (first_idx != 6) begin
      n_fail++;
      $display("FAIL release_latency: got %0d expected 6", first_idx);
    end
    n_checks++;
    if (rels != 1) begin
      n_fail++;
      $display("FAIL release_count: got %0d expected 1", rels);
    end
    n_checks++;
    if (run !== 1'b1) begin
      n_fail++;
      $display("FAIL release_run: got %b expected 1", run);
    end
    $display("test_release_bounce done: latency=%0d releases=%0d", first_idx, rels);
  endtask

  task automatic test_toggle();
    int presses;
    int rels;
    int overlap;
    logic exp_run;
    logic [2:0] exp_seq;
    presses = 0;
    rels    = 0;
    overlap = 0;
    exp_seq = 3'b101;  // run after press k is exp_seq[k]
    rst = 1'b0;
    step();
    step();
    rst   = 1'b1;
    btn_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    for (int k = 0; k < 3; k++) begin
      exp_run = exp_seq[k];
      btn_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (press === 1'b1) presses++;
        if (press === 1'b1 && release_o === 1'b1) overlap++;
      end
      n_checks++;
      if (run !== exp_run) begin
        n_fail++;
        $display("FAIL toggle_run_press%0d: got %b expected %b", k, run, exp_run);
      end
      btn_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step();
        if (release_o === 1'b1) rels++;
        if (press === 1'b1 && release_o === 1'b1) overlap++;
      end
      n_checks++;
      if (run !== exp_run) begin
        n_fail++;
        $display("FAIL toggle_run_release%0d: got %b expected %b", k, run, exp_run);
      end
      $display("toggle cycle %0d: run=%b", k, run);
    end
    n_checks++;
    if (presses != 3 || rels != 3) begin
      n_fail++;
      $display("FAIL toggle_counts: got press=%0d release=%0d expected 3 3", presses, rels);
    end
    n_checks++;
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL toggle_overlap: got %0d expected 0", overlap);
    end
  endtask

`ifdef BTN_LONG_PRESS_EN
  task automatic test_long_press();
    int longs;
    int first_idx;
    int waited;
    longs     = 0;
    first_idx = -1;
    rst = 1'b0;
    step();
    rst   = 1'b1;
    btn_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    btn_n  = 1'b0;
    waited = 0;
    while (press !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    n_checks++;
    if (press !== 1'b1) begin
      n_fail++;
      $display("FAIL long_wait_press: press=%b after %0d cycles expected 1", press, waited);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      if (long_press === 1'b1) begin
        longs++;
        if (first_idx < 0) first_idx = i;
      end
    end
    n_checks++;
    if (first_idx != 10) begin
      n_fail++;
      $display("FAIL long_latency: got %0d expected 10", first_idx);
    end
    n_checks++;
    if (longs != 1) begin
      n_fail++;
      $display("FAIL long_count: got %0d expected 1", longs);
    end
    n_checks++;
    if (run !== 1'b1) begin
      n_fail++;
      $display("FAIL long_run: got %b expected 1", run);
    end
    $display("long press: latency=%0d pulses=%0d", first_idx, longs);
    btn_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    // Second hold interrupted by reset before the hold timer can expire.
    longs  = 0;
    btn_n  = 1'b0;
    waited = 0;
    while (press !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (long_press === 1'b1) longs++;
    end
    rst = 1'b0;
    step();
    step();
    rst   = 1'b1;
    btn_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (long_press === 1'b1) longs++;
    end
    n_checks++;
    if (longs != 0) begin
      n_fail++;
      $display("FAIL long_reset_abort: got %0d pulses expected 0", longs);
    end
    $display("long press with reset: pulses=%0d", longs);
  endtask
`endif

  initial begin
    rst   = 1'b0;
    btn_n = 1'b1;
    test_reset();
    test_bounce();
    test_clean_press();
    test_release_bounce();
    test_toggle();
`ifdef BTN_LONG_PRESS_EN
    test_long_press();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
